// File: rtl/ifft_frame_gen.sv
// ifft_frame_gen: streams one Hermitian-symmetric 1024-bin spectrum frame
// (sine / square / triangle harmonic series) as AXI-Stream into the IFFT.
// Bins leave in natural order 0..N_BINS-1 with tlast on the final bin.
// Optional build macro: IFFT_GEN_AUTO_REPEAT_EN, which restarts a new frame
// after every DONE and re-latches the waveform parameters at that boundary.
module ifft_frame_gen #(
  parameter int N_BINS = 1024,
  parameter int AMP_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       wave_type,
  input  logic [8:0]       freq_bin,
  input  logic [AMP_W-1:0] amplitude,
  output logic [47:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             frame_done
);

  localparam int IDX_W  = $clog2(N_BINS);
  localparam int POS_W  = IDX_W + 2;
  localparam int PROD_W = AMP_W + 16;

  localparam logic [IDX_W-1:0] UPPER_FIRST = IDX_W'(N_BINS / 2 + 1);
  localparam logic [IDX_W-1:0] LAST_BIN    = IDX_W'(N_BINS - 1);
  localparam logic [POS_W-1:0] LOWER_MAX   = POS_W'(N_BINS / 2 - 1);
  localparam logic [POS_W-1:0] FRAME_LEN   = POS_W'(N_BINS);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOWER,
    UPPER,
    DONE
  } state_t;

  state_t state;

  logic [1:0]        wave_q;
  logic [8:0]        k_q;
  logic [AMP_W-1:0]  amp_q;

  logic [IDX_W-1:0]  idx;
  logic signed [5:0] harm_n;
  logic signed [5:0] last_n;
  logic [POS_W-1:0]  next_pos;
  logic [IDX_W-1:0]  last_pos;

  logic              active;
  logic              at_upper_entry;
  logic              in_upper;
  logic signed [5:0] eff_n;
  logic [POS_W-1:0]  eff_pos;
  logic              allowed;
  logic              hit;
  logic signed [5:0] n_after;
  logic [POS_W-1:0]  pos_after;
  logic [2:0]        rom_idx;
  logic [15:0]       coef;
  logic [AMP_W-1:0]  mag;
  logic [23:0]       mag_ext;
  logic [23:0]       re_val;
  logic [47:0]       bin_data;

  // Harmonic tracker: decides whether bin idx carries a harmonic and what the tracker becomes after it
  always_comb begin
    active         = (k_q != 9'd0) && (wave_q != 2'd3);
    at_upper_entry = (idx == UPPER_FIRST);
    in_upper       = (idx >= UPPER_FIRST);
    eff_n          = at_upper_entry ? last_n : harm_n;
    eff_pos        = at_upper_entry ? (FRAME_LEN - POS_W'(last_pos)) : next_pos;
    allowed        = 1'b0;
    if (in_upper) begin
      allowed = (eff_n > 6'sd0);
    end else begin
      allowed = (eff_pos <= LOWER_MAX) &&
                ((wave_q == 2'd0) ? (eff_n == 6'sd1) : (eff_n <= 6'sd15));
    end
    hit       = active && allowed && (eff_pos == POS_W'(idx));
    n_after   = eff_n;
    pos_after = eff_pos;
    if (hit) begin
      n_after   = in_upper ? (eff_n - 6'sd2) : (eff_n + 6'sd2);
      pos_after = eff_pos + POS_W'({k_q, 1'b0});
    end
    rom_idx = eff_n[3:1];
  end

  // Q1.15 coefficient ROM: sine is a single full-scale line, square falls as 1/n, triangle as 1/n^2
  always_comb begin
    coef = 16'd0;
    case (wave_q)
      2'd0: coef = 16'd32767;
      2'd1: begin
        case (rom_idx)
          3'd0: coef = 16'd32767;
          3'd1: coef = 16'd10923;
          3'd2: coef = 16'd6554;
          3'd3: coef = 16'd4681;
          3'd4: coef = 16'd3641;
          3'd5: coef = 16'd2979;
          3'd6: coef = 16'd2521;
          default: coef = 16'd2185;
        endcase
      end
      2'd2: begin
        case (rom_idx)
          3'd0: coef = 16'd32767;
          3'd1: coef = 16'd3641;
          3'd2: coef = 16'd1311;
          3'd3: coef = 16'd669;
          3'd4: coef = 16'd405;
          3'd5: coef = 16'd271;
          3'd6: coef = 16'd194;
          default: coef = 16'd146;
        endcase
      end
      default: coef = 16'd0;
    endcase
  end

  // Scale by amplitude, truncate after the Q15 shift, then negate alternate triangle harmonics
  always_comb begin
    mag      = AMP_W'((PROD_W'(amp_q) * PROD_W'(coef)) >> 15);
    mag_ext  = 24'(mag);
    re_val   = 24'd0;
    if (hit) begin
      re_val = ((wave_q == 2'd2) && rom_idx[0]) ? (24'd0 - mag_ext) : mag_ext;
    end
    bin_data = {24'd0, re_val};
  end

  // Frame FSM with registered AXI-Stream output stage; the tracker only moves on a handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wave_q        <= 2'd0;
      k_q           <= 9'd0;
      amp_q         <= '0;
      idx           <= '0;
      harm_n        <= 6'sd1;
      last_n        <= 6'sd1;
      next_pos      <= '0;
      last_pos      <= '0;
      m_axis_tdata  <= 48'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            wave_q <= wave_type;
            k_q    <= freq_bin;
            amp_q  <= amplitude;
            busy   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          // DC never carries a harmonic, so bin 0 is presented as zero right away
          idx           <= IDX_W'(1);
          harm_n        <= 6'sd1;
          last_n        <= 6'sd1;
          next_pos      <= POS_W'(k_q);
          last_pos      <= '0;
          m_axis_tdata  <= 48'd0;
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= 1'b0;
          state         <= LOWER;
        end
        LOWER, UPPER: begin
          if (m_axis_tvalid && m_axis_tready) begin
            if (m_axis_tlast) begin
              m_axis_tdata  <= 48'd0;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              frame_done    <= 1'b1;
`ifdef IFFT_GEN_AUTO_REPEAT_EN
              busy          <= 1'b1;
`else
              busy          <= 1'b0;
`endif
              state         <= DONE;
            end else begin
              m_axis_tdata <= bin_data;
              m_axis_tlast <= (idx == LAST_BIN);
              idx          <= idx + 1'b1;
              harm_n       <= n_after;
              next_pos     <= pos_after;
              if (hit && !in_upper) begin
                last_n   <= eff_n;
                last_pos <= idx;
              end
              if (at_upper_entry) begin
                state <= UPPER;
              end
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
`ifdef IFFT_GEN_AUTO_REPEAT_EN
          wave_q     <= wave_type;
          k_q        <= freq_bin;
          amp_q      <= amplitude;
          state      <= SETUP;
`else
          state      <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft_frame_gen.sv
// tb_ifft_frame_gen: directed bench for ifft_frame_gen with hand-computed
// spectrum bins, backpressure, edge cases and mid-frame reset.
// Honours IFFT_GEN_AUTO_REPEAT_EN when the design is built with it.
module tb_ifft_frame_gen;

  localparam int N_BINS = 1024;
  localparam int AMP_W  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       wave_type = 2'd0;
  logic [8:0]       freq_bin = 9'd0;
  logic [AMP_W-1:0] amplitude = '0;
  logic [47:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b0;
  logic             m_axis_tlast;
  logic             busy;
  logic             frame_done;

  int n_errors = 0;
  int n_checks = 0;
  int beat_cnt = 0;

  logic [47:0]        got_data [N_BINS];
  logic               got_last [N_BINS];
  logic signed [23:0] exp_re   [N_BINS];

  ifft_frame_gen #(.N_BINS(N_BINS), .AMP_W(AMP_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .wave_type     (wave_type),
    .freq_bin      (freq_bin),
    .amplitude     (amplitude),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearExpected();
    foreach (exp_re[i]) exp_re[i] = 24'sd0;
  endtask

  // Pulse start from a negedge, then check SETUP and the two-cycle latency to bin 0
  task automatic applyStimulus(input logic [1:0] w, input logic [8:0] k, input logic [AMP_W-1:0] a);
    wave_type = w;
    freq_bin  = k;
    amplitude = a;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("setup_busy", 48'(busy), 48'd1);
    checkOutput("setup_tvalid", 48'(m_axis_tvalid), 48'd0);
    @(negedge clk);
    checkOutput("latency_tvalid", 48'(m_axis_tvalid), 48'd1);
    checkOutput("latency_bin0", m_axis_tdata, 48'd0);
  endtask

  // Consume beats at negedges; optional stall, start poke and early stop, bounded by a cycle budget
  task automatic collectFrame(input int stall_bin, input int stall_len, input int poke_bin, input int stop_bin);
    int stall_left;
    bit seen_last;
    stall_left = stall_len;
    seen_last  = 1'b0;
    beat_cnt   = 0;
    foreach (got_data[i]) begin
      got_data[i] = 'x;
      got_last[i] = 1'bx;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (seen_last || beat_cnt == stop_bin || beat_cnt >= N_BINS) break;
      checkOutput("tvalid_held", 48'(m_axis_tvalid), 48'd1);
      if (beat_cnt == stall_bin && stall_left > 0) begin
        m_axis_tready = 1'b0;
        start = 1'b0;
        checkOutput("stall_tdata", m_axis_tdata, {24'd0, exp_re[stall_bin]});
        checkOutput("stall_tlast", 48'(m_axis_tlast), 48'd0);
        stall_left--;
      end else begin
        m_axis_tready = 1'b1;
        start = (beat_cnt == poke_bin);
        if (m_axis_tvalid === 1'b1) begin
          got_data[beat_cnt] = m_axis_tdata;
          got_last[beat_cnt] = m_axis_tlast;
          seen_last = (m_axis_tlast === 1'b1);
          beat_cnt++;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (stop_bin < 0) checkOutput("frame_has_tlast", 48'(seen_last), 48'd1);
  endtask

  // Called on the negedge right after the tlast handshake
  task automatic checkFrameEnd();
    checkOutput("frame_done_pulse", 48'(frame_done), 48'd1);
    checkOutput("done_tvalid_low", 48'(m_axis_tvalid), 48'd0);
`ifdef IFFT_GEN_AUTO_REPEAT_EN
    checkOutput("done_busy", 48'(busy), 48'd1);
`else
    checkOutput("done_busy", 48'(busy), 48'd0);
`endif
    @(negedge clk);
    checkOutput("frame_done_single", 48'(frame_done), 48'd0);
  endtask

  task automatic checkFrame(input string name);
    checkOutput($sformatf("%s_beats", name), 48'(beat_cnt), 48'd1024);
    for (int i = 0; i < N_BINS; i++) begin
      checkOutput($sformatf("%s_bin%0d", name, i), got_data[i], {24'd0, exp_re[i]});
      checkOutput($sformatf("%s_tlast%0d", name, i), 48'(got_last[i]), 48'((i == N_BINS - 1) ? 1 : 0));
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput($sformatf("%s_tdata", name), m_axis_tdata, 48'd0);
    checkOutput($sformatf("%s_tvalid", name), 48'(m_axis_tvalid), 48'd0);
    checkOutput($sformatf("%s_tlast", name), 48'(m_axis_tlast), 48'd0);
    checkOutput($sformatf("%s_busy", name), 48'(busy), 48'd0);
    checkOutput($sformatf("%s_frame_done", name), 48'(frame_done), 48'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b1;
    @(negedge clk);

`ifdef IFFT_GEN_AUTO_REPEAT_EN
    // Back-to-back frames; a new k written mid-frame only shows up in the next frame
    clearExpected();
    exp_re[10]   = 24'sd999;
    exp_re[1014] = 24'sd999;
    applyStimulus(2'd0, 9'd10, 16'd1000);
    freq_bin = 9'd20;
    collectFrame(-1, 0, -1, -1);
    checkFrameEnd();
    checkFrame("auto1");
    @(negedge clk);
    checkOutput("auto_busy_between", 48'(busy), 48'd1);
    clearExpected();
    exp_re[20]   = 24'sd999;
    exp_re[1004] = 24'sd999;
    collectFrame(-1, 0, -1, -1);
    checkFrameEnd();
    checkFrame("auto2");
    rst = 1'b0;
    #1;
    checkResetOutputs("auto_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`else
    // Sine k=10: a single line at 10 and its mirror at 1014
    clearExpected();
    exp_re[10]   = 24'sd999;
    exp_re[1014] = 24'sd999;
    applyStimulus(2'd0, 9'd10, 16'd1000);
    collectFrame(-1, 0, -1, -1);
    checkFrameEnd();
    checkFrame("sine");

    // Square k=100: odd harmonics 1,3,5 with 1/n weights
    clearExpected();
    exp_re[100] = 24'sd16383;
    exp_re[924] = 24'sd16383;
    exp_re[300] = 24'sd5461;
    exp_re[724] = 24'sd5461;
    exp_re[500] = 24'sd3277;
    exp_re[524] = 24'sd3277;
    applyStimulus(2'd1, 9'd100, 16'd16384);
    collectFrame(-1, 0, -1, -1);
    checkFrameEnd();
    checkFrame("square");

    // Triangle k=100: alternating signs with 1/n^2 weights
    clearExpected();
    exp_re[100] = 24'sd16383;
    exp_re[924] = 24'sd16383;
    exp_re[300] = -24'sd1820;
    exp_re[724] = -24'sd1820;
    exp_re[500] = 24'sd655;
    exp_re[524] = 24'sd655;
    applyStimulus(2'd2, 9'd100, 16'd16384);
    collectFrame(-1, 0, -1, -1);
    checkFrameEnd();
    checkFrame("triangle");

    // Backpressure: tready low for 3 cycles while bin 10 is presented
    clearExpected();
    exp_re[10]   = 24'sd999;
    exp_re[1014] = 24'sd999;
    applyStimulus(2'd0, 9'd10, 16'd1000);
    collectFrame(10, 3, -1, -1);
    checkFrameEnd();
    checkFrame("stall");

    // freq_bin = 0 gives an all-zero frame
    clearExpected();
    applyStimulus(2'd1, 9'd0, 16'd16384);
    collectFrame(-1, 0, -1, -1);
    checkFrameEnd();
    checkFrame("k0");

    // Reserved wave type gives an all-zero frame
    clearExpected();
    applyStimulus(2'd3, 9'd10, 16'd1000);
    collectFrame(-1, 0, -1, -1);
    checkFrameEnd();
    checkFrame("wave3");

    // start pulsed mid-frame is dropped: no second frame follows
    clearExpected();
    exp_re[10]   = 24'sd999;
    exp_re[1014] = 24'sd999;
    applyStimulus(2'd0, 9'd10, 16'd1000);
    collectFrame(-1, 0, 200, -1);
    checkFrameEnd();
    checkFrame("busy_start");
    repeat (5) @(negedge clk);
    checkOutput("no_second_frame_busy", 48'(busy), 48'd0);
    checkOutput("no_second_frame_tvalid", 48'(m_axis_tvalid), 48'd0);

    // Reset while bin 400 is presented: outputs clear asynchronously
    applyStimulus(2'd0, 9'd10, 16'd1000);
    collectFrame(-1, 0, -1, 400);
    checkOutput("abort_at_bin400", 48'(beat_cnt), 48'd400);
    rst = 1'b0;
    #1;
    checkResetOutputs("abort");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Clean frame after the abort starts from bin 0
    clearExpected();
    exp_re[10]   = 24'sd999;
    exp_re[1014] = 24'sd999;
    applyStimulus(2'd0, 9'd10, 16'd1000);
    collectFrame(-1, 0, -1, -1);
    checkFrameEnd();
    checkFrame("post_reset");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
